// File: rtl/usb_buf_pkg.sv
// Shared constants and types for the USB payload byte buffer.
// Imported by the buffer top and its storage sub-module.
package usb_buf_pkg;

    localparam int BUF_DEPTH  = 64;
    localparam int BUF_DATA_W = 8;
    localparam int BUF_OCC_W  = 7;
    localparam int BUF_PTR_W  = 6;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_AHB  = 2'd1,
        POP_TX   = 2'd2
    } pop_side_e;

endpackage

// File: rtl/usb_buffer_ram.sv
// Byte storage for the USB buffer: one write port, one registered read port.
// Kept separate so it can later be swapped for a RAM macro.
module usb_buffer_ram
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int DATA_W = BUF_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write contents when both ports hit one entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between the AHB USB slave and the TX/RX packet engines.
// Handles push/pop arbitration, occupancy, sticky error flags and flush.
module usb_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int DATA_W = BUF_DATA_W,
    parameter int OCC_W  = BUF_OCC_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              flush,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_rx_data,
    output logic [DATA_W-1:0] rx_data,
    input  logic              store_rx_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    pop_side_e         side_q, side_d;
    logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;

    logic              flush_req;
    logic              full, empty;
    logic              push, pop;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] push_byte;
    logic [DATA_W-1:0] ram_rdata;

    assign flush_req = clear | flush;
    assign full      = (count_q == OCC_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = store_tx_data | store_rx_packet_data;
    assign pop       = get_rx_data | get_tx_packet_data;
    assign push_byte = store_tx_data ? tx_data : rx_packet_data;

    // A full buffer still accepts a push when a pop frees a slot this cycle.
    assign pop_ok  = pop & ~empty & ~flush_req;
    assign push_ok = push & (~full | pop_ok) & ~flush_req;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        side_d    = POP_NONE;
        rx_hold_d = rx_hold_q;
        tx_hold_d = tx_hold_q;
        if (side_q == POP_AHB) begin
            rx_hold_d = ram_rdata;
        end
        if (side_q == POP_TX) begin
            tx_hold_d = ram_rdata;
        end
        if (flush_req) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
                side_d = get_tx_packet_data ? POP_TX : POP_AHB;
            end
            count_d = count_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
            if ((push & ~push_ok) |
                (store_tx_data & store_rx_packet_data)) begin
                ovf_d = 1'b1;
            end
            if ((pop & empty) |
                (get_tx_packet_data & get_rx_data)) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            side_q    <= POP_NONE;
            rx_hold_q <= '0;
            tx_hold_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            side_q    <= side_d;
            rx_hold_q <= rx_hold_d;
            tx_hold_q <= tx_hold_d;
        end
    end

    usb_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk     (clk),
        .n_rst   (n_rst),
        .we_i    (push_ok),
        .waddr_i (wptr_q),
        .wdata_i (push_byte),
        .re_i    (pop_ok),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register carries the newest byte; each side otherwise
    // shows its own held copy so the other side's pops do not disturb it.
    assign rx_data          = (side_q == POP_AHB) ? ram_rdata : rx_hold_q;
    assign tx_packet_data   = (side_q == POP_TX) ? ram_rdata : tx_hold_q;
    assign buffer_occupancy = count_q;
    assign overflow         = ovf_q;
    assign underflow        = udf_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: directed pushes/pops, expected
// pop bytes queued by stimulus and checked by an independent monitor.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       flush = 1'b0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = '0;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = '0;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       overflow;
    logic       underflow;

    int n_chk = 0;
    int n_fail = 0;

    // {side (1 = TX engine, 0 = AHB), expected byte}
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    usb_data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .flush                (flush),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        store_tx_data = 1'b1;
        tx_data = b;
        step();
        store_tx_data = 1'b0;
    endtask

    task automatic pop_tx(input logic [7:0] e);
        get_tx_packet_data = 1'b1;
        exp_q.push_back({1'b1, e});
        step();
        get_tx_packet_data = 1'b0;
    endtask

    task automatic pop_rx(input logic [7:0] e);
        get_rx_data = 1'b1;
        exp_q.push_back({1'b0, e});
        step();
        get_rx_data = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Monitor: any pop strobe seen at an edge yields one output to check.
    initial begin
        logic       ptx, prx;
        logic [8:0] e;
        forever begin
            @(posedge clk);
            ptx = n_rst && get_tx_packet_data && !(clear || flush);
            prx = n_rst && get_rx_data && !get_tx_packet_data
                  && !(clear || flush);
            @(negedge clk);
            if (ptx || prx) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_side", {31'd0, ptx}, {31'd0, e[8]});
                    if (ptx) chk("tx_packet_data", tx_packet_data, e[7:0]);
                    else     chk("rx_data", rx_data, e[7:0]);
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_occ", buffer_occupancy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_tx", tx_packet_data, 0);
        step();
        n_rst = 1'b1;
        step();

        // Four-byte AHB word in, TX engine drains it.
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44);
        chk("word_occ4", buffer_occupancy, 4);
        pop_tx(8'h11); pop_tx(8'h22); pop_tx(8'h33); pop_tx(8'h44);
        chk("word_occ0", buffer_occupancy, 0);

        // Fill to capacity with pointers offset, overflow, full push+pop.
        for (int i = 0; i < 64; i++) push_tx(8'(i));
        chk("full_occ", buffer_occupancy, 64);
        chk("full_ovf0", overflow, 0);
        push_tx(8'hFF);
        chk("ovf_set", overflow, 1);
        chk("ovf_occ", buffer_occupancy, 64);
        store_tx_data = 1'b1;
        tx_data = 8'hEE;
        pop_tx(8'h00);
        store_tx_data = 1'b0;
        chk("full_pushpop_occ", buffer_occupancy, 64);
        for (int i = 1; i < 64; i++) pop_tx(8'(i));
        pop_tx(8'hEE);
        chk("drain_occ", buffer_occupancy, 0);

        // AHB pop on empty buffer.
        pop_rx(8'h00);
        chk("udf_set", underflow, 1);
        chk("udf_occ", buffer_occupancy, 0);
        pulse_clear();
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);

        // Push and pop in one cycle at occupancy 5.
        for (int i = 1; i <= 5; i++) push_tx(8'(i));
        store_tx_data = 1'b1;
        tx_data = 8'hAB;
        pop_tx(8'h01);
        store_tx_data = 1'b0;
        chk("pp_occ5", buffer_occupancy, 5);
        pop_rx(8'h02);
        chk("tx_held", tx_packet_data, 8'h01);
        pop_rx(8'h03); pop_rx(8'h04); pop_rx(8'h05); pop_rx(8'hAB);
        chk("pp_occ0", buffer_occupancy, 0);

        // Occupancy 10 with overflow, then clear beside a push.
        for (int i = 0; i < 9; i++) push_tx(8'h60 + 8'(i));
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'hC3;
        push_tx(8'h5A);
        store_rx_packet_data = 1'b0;
        chk("o10_occ", buffer_occupancy, 10);
        chk("o10_ovf", overflow, 1);
        clear = 1'b1;
        push_tx(8'h77);
        clear = 1'b0;
        chk("clrpush_occ", buffer_occupancy, 0);
        chk("clrpush_ovf", overflow, 0);
        push_tx(8'h99);
        pop_tx(8'h99);

        // Both push sources at once: AHB byte kept, RX byte dropped.
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'hC3;
        push_tx(8'h5A);
        store_rx_packet_data = 1'b0;
        chk("dual_occ", buffer_occupancy, 1);
        chk("dual_ovf", overflow, 1);
        pop_tx(8'h5A);
        chk("dual_occ0", buffer_occupancy, 0);

        // Push and pop on empty: no fall-through.
        store_tx_data = 1'b1;
        tx_data = 8'h42;
        pop_tx(8'h5A);
        store_tx_data = 1'b0;
        chk("emp_pp_occ", buffer_occupancy, 1);
        chk("emp_pp_udf", underflow, 1);
        pop_tx(8'h42);

        // Held flush keeps the buffer empty.
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_tx(8'hD0 + 8'(i));
            chk("flush_occ", buffer_occupancy, 0);
        end
        flush = 1'b0;
        chk("flush_flags", {30'd0, overflow, underflow}, 0);
        chk("flush_tx_kept", tx_packet_data, 8'h42);

        // Async reset in the middle of a word.
        push_tx(8'h01); push_tx(8'h02);
        store_tx_data = 1'b1;
        tx_data = 8'h03;
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_occ", buffer_occupancy, 0);
        chk("arst_tx", tx_packet_data, 0);
        chk("arst_rx", rx_data, 0);
        store_tx_data = 1'b0;
        step();
        n_rst = 1'b1;
        step();
        pop_tx(8'h00);
        chk("arst_udf", underflow, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
